// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - RV32I decode types, encodings and the ID_EX bundle
package riscv_pkg;

    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_SLTU    = 3'b011;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SRL_SRA = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic [4:0] {
        ALU_NONE, ALU_ADDI, ALU_SLTI, ALU_SLTIU, ALU_XORI, ALU_ORI, ALU_ANDI,
        ALU_SLLI, ALU_SRLI, ALU_SRAI, ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT,
        ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_JAL
    } alu_op_t;

    typedef enum logic [1:0] {ST_RUN, ST_STALL, ST_SQUASH} dec_state_t;

    typedef struct packed {
        alu_op_t     alu_op;
        logic [31:0] inst_imm_sgn;
        logic [4:0]  shamt;
        logic [31:0] pc;
        logic [4:0]  reg_wr_addr;
        logic        rd_wr_en;
        logic        do_not_execute;
    } id_ex_t;

    localparam id_ex_t ID_EX_BUBBLE = '{
        alu_op: ALU_NONE, inst_imm_sgn: 32'd0, shamt: 5'd0, pc: 32'd0,
        reg_wr_addr: 5'd0, rd_wr_en: 1'b0, do_not_execute: 1'b1
    };

    // A writer of x0 never creates a dependency.
    function automatic logic raw_hit(input logic wr_en, input logic [4:0] rd,
                                     input logic [4:0] rs1, input logic [4:0] rs2,
                                     input logic use_rs1, input logic use_rs2);
        return wr_en && (rd != 5'd0) &&
               ((use_rs1 && (rd == rs1)) || (use_rs2 && (rd == rs2)));
    endfunction

endpackage

// File: rtl/decode_stage_if.sv
// rtl/decode_stage_if.sv - fetch/decode handshake and redirect bundle
interface decode_stage_if;
    logic        if_valid;
    logic [31:0] if_inst;
    logic [31:0] if_pc;
    logic        id_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    modport master (
        output if_valid, if_inst, if_pc,
        input  id_ready, redirect_valid, redirect_pc
    );

    modport slave (
        input  if_valid, if_inst, if_pc,
        output id_ready, redirect_valid, redirect_pc
    );
endinterface

// File: rtl/imm_gen.sv
// rtl/imm_gen.sv - I-type and J-type immediate extraction with sign extension
module imm_gen (
    input  logic [31:12] inst,
    output logic [31:0]  imm_i,
    output logic [31:0]  imm_j
);
    assign imm_i = {{20{inst[31]}}, inst[31:20]};
    assign imm_j = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
endmodule

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - RV32I decode: RAW interlock, JAL redirect and registered ID_EX bundle
module decode_stage
    import riscv_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int WB_BYPASS = 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    decode_stage_if.slave        fetch,
    output logic [4:0]           rs1_addr,
    output logic [4:0]           rs2_addr,
    input  logic                 ex_wb_wr_en,
    input  logic [4:0]           ex_wb_wr_addr,
    output logic                 illegal_inst,
    output id_ex_t               id_ex_r
);
    dec_state_t     state;
    logic           redirect_valid_r;
    logic [31:0]    redirect_pc_r;

    logic [6:0]     opcode;
    logic [2:0]     funct3;
    logic [6:0]     funct7;
    logic [4:0]     rd;
    logic [31:0]    imm_i;
    logic [31:0]    imm_j;
    logic [XLEN-1:0] link_pc;
    logic [XLEN-1:0] jal_target;

    alu_op_t        dec_op;
    logic           dec_legal;
    logic           uses_rs1;
    logic           uses_rs2;
    logic           is_jal;
    logic           haz;

    dec_state_t     next_state;
    id_ex_t         next_id_ex;
    logic           next_redirect;
    logic           next_illegal;

    assign opcode   = fetch.if_inst[6:0];
    assign rd       = fetch.if_inst[11:7];
    assign funct3   = fetch.if_inst[14:12];
    assign rs1_addr = fetch.if_inst[19:15];
    assign rs2_addr = fetch.if_inst[24:20];
    assign funct7   = fetch.if_inst[31:25];

    imm_gen u_imm_gen (
        .inst  (fetch.if_inst[31:12]),
        .imm_i (imm_i),
        .imm_j (imm_j)
    );

    assign link_pc    = fetch.if_pc + 32'd4;
    assign jal_target = fetch.if_pc + imm_j;

    always_comb begin
        dec_op    = ALU_NONE;
        dec_legal = 1'b0;
        uses_rs1  = 1'b0;
        uses_rs2  = 1'b0;
        is_jal    = 1'b0;
        case (opcode)
            OPC_OP_IMM: begin
                uses_rs1  = 1'b1;
                dec_legal = 1'b1;
                case (funct3)
                    F3_ADD_SUB: dec_op = ALU_ADDI;
                    F3_SLT:     dec_op = ALU_SLTI;
                    F3_SLTU:    dec_op = ALU_SLTIU;
                    F3_XOR:     dec_op = ALU_XORI;
                    F3_OR:      dec_op = ALU_ORI;
                    F3_AND:     dec_op = ALU_ANDI;
                    F3_SLL:     if (funct7 == F7_BASE) dec_op = ALU_SLLI;
                                else dec_legal = 1'b0;
                    default: begin
                        if (funct7 == F7_BASE)     dec_op = ALU_SRLI;
                        else if (funct7 == F7_ALT) dec_op = ALU_SRAI;
                        else                       dec_legal = 1'b0;
                    end
                endcase
            end
            OPC_OP: begin
                uses_rs1  = 1'b1;
                uses_rs2  = 1'b1;
                dec_legal = 1'b1;
                if (funct7 == F7_BASE) begin
                    case (funct3)
                        F3_ADD_SUB: dec_op = ALU_ADD;
                        F3_SLL:     dec_op = ALU_SLL;
                        F3_SLT:     dec_op = ALU_SLT;
                        F3_SLTU:    dec_op = ALU_SLTU;
                        F3_XOR:     dec_op = ALU_XOR;
                        F3_SRL_SRA: dec_op = ALU_SRL;
                        F3_OR:      dec_op = ALU_OR;
                        default:    dec_op = ALU_AND;
                    endcase
                end else if (funct7 == F7_ALT && funct3 == F3_ADD_SUB) begin
                    dec_op = ALU_SUB;
                end else if (funct7 == F7_ALT && funct3 == F3_SRL_SRA) begin
                    dec_op = ALU_SRA;
                end else begin
                    dec_legal = 1'b0;
                end
            end
            OPC_JAL: begin
                is_jal    = 1'b1;
                dec_legal = 1'b1;
                dec_op    = ALU_JAL;
            end
            default: ;
        endcase
    end

    // Without a regfile write bypass the WB writer is still one cycle from being readable.
    assign haz = raw_hit(id_ex_r.rd_wr_en & ~id_ex_r.do_not_execute, id_ex_r.reg_wr_addr,
                         rs1_addr, rs2_addr, uses_rs1, uses_rs2) ||
                 ((WB_BYPASS == 0) &&
                  raw_hit(ex_wb_wr_en, ex_wb_wr_addr, rs1_addr, rs2_addr, uses_rs1, uses_rs2));

    assign fetch.id_ready = (state == ST_SQUASH) || !haz;

    always_comb begin
        next_state    = state;
        next_id_ex    = ID_EX_BUBBLE;
        next_redirect = 1'b0;
        next_illegal  = 1'b0;
        if (state == ST_SQUASH) begin
            if (fetch.if_valid) next_state = ST_RUN;
        end else if (!fetch.if_valid) begin
            next_state = ST_RUN;
        end else if (haz) begin
            next_state = ST_STALL;
        end else if (!dec_legal) begin
            next_state   = ST_RUN;
            next_illegal = 1'b1;
        end else begin
            next_state                = is_jal ? ST_SQUASH : ST_RUN;
            next_redirect             = is_jal;
            next_id_ex.alu_op         = dec_op;
            next_id_ex.inst_imm_sgn   = imm_i;
            next_id_ex.shamt          = fetch.if_inst[24:20];
            next_id_ex.pc             = is_jal ? link_pc : fetch.if_pc;
            next_id_ex.reg_wr_addr    = rd;
            next_id_ex.rd_wr_en       = (rd != 5'd0);
            next_id_ex.do_not_execute = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state            <= ST_RUN;
            id_ex_r          <= ID_EX_BUBBLE;
            redirect_valid_r <= 1'b0;
            redirect_pc_r    <= 32'd0;
            illegal_inst     <= 1'b0;
        end else begin
            state            <= next_state;
            id_ex_r          <= next_id_ex;
            redirect_valid_r <= next_redirect;
            redirect_pc_r    <= jal_target;
            illegal_inst     <= next_illegal;
        end
    end

    assign fetch.redirect_valid = redirect_valid_r;
    assign fetch.redirect_pc    = redirect_pc_r;

endmodule
